// File: rtl/divider16_seq.sv
// divider16_seq: multi-cycle unsigned restoring divider for the ALU datapath.
//
// One trial subtraction per clock. A start accepted at edge k with B != 0
// gives WIDTH+1 cycles of busy (one load cycle is folded into the first of
// them, WIDTH iteration edges, one result-transfer edge). done then pulses
// for one cycle. With B == 0 the block spends one busy cycle in DIVZ and
// then pulses done.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        launch request, accepted when busy == 0 (IDLE or DONE)
//   A, B         dividend / divisor, captured on the accepting edge
//   busy         a division is in flight
//   done         one-cycle pulse when Q/R/div_by_zero are updated
//   Q, R         quotient / remainder, held until the next done
//   div_by_zero  captured divisor was zero (Q = all ones, R = A)
module divider16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DIVZ, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] dq;    // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  // Trial subtraction at WIDTH+1 bits; the top bit is the borrow.
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_sh = {rem[WIDTH-2:0], dq[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {1'b0, b_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      dq          <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            busy  <= 1'b1;
            if (B == '0) begin
              state <= DIVZ;
            end else begin
              state <= RUN;
              rem   <= '0;
              cnt   <= '0;
              dq    <= A;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          if (cnt == CNT_LAST) begin
            // All quotient bits formed; publish on this edge.
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            Q           <= dq;
            R           <= rem;
            div_by_zero <= 1'b0;
          end else begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              dq  <= {dq[WIDTH-2:0], 1'b1};
            end else begin
              rem <= rem_sh;
              dq  <= {dq[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end

        DIVZ: begin
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          Q           <= '1;
          R           <= a_reg;
          div_by_zero <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider16_seq.sv
// Directed bench for divider16_seq: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_divider16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [15:0] R;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive start for one edge; returns at the falling edge after acceptance.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded). lat = sample index of done (1 = first sample
  // after the accepting edge), bcnt = busy samples before it.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #3;
    checks++;
    if ({busy, done, Q, R, div_by_zero} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, Q, R, div_by_zero});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    start_op(16'd100, 16'd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    wait_done(lat, bcnt);
    checks++;
    if (lat != 18) begin errors++; $display("FAIL basic_latency: got %0d expected 18", lat); end
    checks++;
    if (bcnt != 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 17", bcnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
    checks++;
    if (Q !== 16'd14 || R !== 16'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: got Q=%0d R=%0d dz=%b expected Q=14 R=2 dz=0", Q, R, div_by_zero);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || Q !== 16'd14 || R !== 16'd2) begin
        errors++; $display("FAIL basic_hold: got done=%b busy=%b Q=%0d R=%0d expected 0 0 14 2", done, busy, Q, R);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    start_op(16'hB333, 16'h4444);
    wait_done(lat, bcnt);
    checks++;
    if (lat != 18 || Q !== 16'd2 || R !== 16'h2AAB) begin
      errors++; $display("FAIL b2b_first: got lat=%0d Q=%h R=%h expected 18 0002 2aab", lat, Q, R);
    end
    // Launch while done is high.
    start_op(16'd65535, 16'd54613);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done, busy);
    end
    checks++;
    if (Q !== 16'd2 || R !== 16'h2AAB) begin
      errors++; $display("FAIL b2b_hold_during_run: got Q=%h R=%h expected 0002 2aab", Q, R);
    end
    wait_done(lat, bcnt);
    checks++;
    if (lat != 18 || bcnt != 17 || Q !== 16'd1 || R !== 16'd10922) begin
      errors++; $display("FAIL b2b_second: got lat=%0d busy=%0d Q=%0d R=%0d expected 18 17 1 10922", lat, bcnt, Q, R);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    start_op(16'd5, 16'd0);
    wait_done(lat, bcnt);
    checks++;
    if (lat != 2 || bcnt != 1) begin
      errors++; $display("FAIL divz_latency: got lat=%0d busy=%0d expected 2 1", lat, bcnt);
    end
    checks++;
    if (Q !== 16'hFFFF || R !== 16'd5 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL divz_result: got Q=%h R=%0d dz=%b expected ffff 5 1", Q, R, div_by_zero);
    end
    @(negedge clk);
    start_op(16'd9, 16'd3);
    checks++;
    if (div_by_zero !== 1'b1 || Q !== 16'hFFFF) begin
      errors++; $display("FAIL divz_hold_during_run: got Q=%h dz=%b expected ffff 1", Q, div_by_zero);
    end
    wait_done(lat, bcnt);
    checks++;
    if (lat != 18 || Q !== 16'd3 || R !== 16'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL divz_next: got lat=%0d Q=%0d R=%0d dz=%b expected 18 3 0 0", lat, Q, R, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_edges;
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vq [3];
    logic [15:0] vr [3];
    int lat, bcnt;
    va[0] = 16'd3;     vb[0] = 16'd10;    vq[0] = 16'd0;     vr[0] = 16'd3;
    va[1] = 16'd65535; vb[1] = 16'd1;     vq[1] = 16'd65535; vr[1] = 16'd0;
    va[2] = 16'd0;     vb[2] = 16'd65535; vq[2] = 16'd0;     vr[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat, bcnt);
      checks++;
      if (lat != 18 || Q !== vq[i] || R !== vr[i] || div_by_zero !== 1'b0) begin
        errors++; $display("FAIL edge_%0d: got lat=%0d Q=%0d R=%0d dz=%b expected 18 %0d %0d 0",
                           i, lat, Q, R, div_by_zero, vq[i], vr[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    start_op(16'd1000, 16'd3);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == 4) begin A = 16'd7; B = 16'd7; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != 18 || Q !== 16'd333 || R !== 16'd1) begin
      errors++; $display("FAIL ignore_start: got lat=%0d Q=%0d R=%0d expected 18 333 1", lat, Q, R);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignore_start_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset;
    int lat, bcnt;
    logic saw_done;
    start_op(16'd1000, 16'd3);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Q, R, div_by_zero} !== 35'd0) begin
      errors++; $display("FAIL async_reset_outputs: got %h expected 0", {busy, done, Q, R, div_by_zero});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL async_reset_no_done: got %b expected 0", saw_done); end
    start_op(16'd50, 16'd5);
    wait_done(lat, bcnt);
    checks++;
    if (lat != 18 || Q !== 16'd10 || R !== 16'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL async_reset_next: got lat=%0d Q=%0d R=%0d dz=%b expected 18 10 0 0", lat, Q, R, div_by_zero);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_edges();
    test_ignore_start();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
